// File: rtl/spi_wb_pkg.sv
// -----------------------------------------------------------------------------
// spi_wb_pkg
// Shared definitions for the SPI-to-Wishbone command bridge:
//   - state_t      : bridge FSM states
//   - CMD_WE_BIT   : command byte bit that selects write (1) or read (0)
//   - CMD_ADR_MSB  : top bit of the address field in the command byte
//   - RD_ERR_BYTE  : byte returned to the SPI master when a read times out
// -----------------------------------------------------------------------------
package spi_wb_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_DATA = 3'd1,
    WB_REQ   = 3'd2,
    WB_WAIT  = 3'd3,
    TX_PUSH  = 3'd4
  } state_t;

  localparam int CMD_WE_BIT  = 7;
  localparam int CMD_ADR_MSB = 6;

  localparam logic [7:0] RD_ERR_BYTE = 8'hFF;

endpackage : spi_wb_pkg

// File: rtl/spi_wb_bridge.sv
// -----------------------------------------------------------------------------
// spi_wb_bridge
// Consumes bytes from the SPI receive path (already in the clk domain, one
// cycle strobes), decodes a 1- or 2-byte command and runs a single 8-bit
// Wishbone classic cycle. Read results go back to the SPI transmit path over
// a valid/ready handshake. Bytes arriving while a command is in flight are
// dropped and counted; a bus cycle with no ack is aborted after TIMEOUT clks.
//
// Command byte: bit7 = we, bits6:0 = address (only addr[AW-1:0] is used).
//   write: <cmd with we=1> <data byte>
//   read : <cmd with we=0>            -> one byte pushed on tx
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   rx_data, rx_stb   received byte and its one-cycle strobe
//   tx_data, tx_stb   read-result byte, held valid until tx_ready
//   tx_ready          transmit path accepts tx_data
//   wb_cyc, wb_stb    Wishbone cycle / strobe
//   wb_we, wb_adr     Wishbone write enable / address
//   wb_dat_o          Wishbone write data
//   wb_dat_i, wb_ack  Wishbone read data / acknowledge
//   overrun           saturating count of dropped bytes
//   timeout           sticky flag, set when a bus cycle was aborted
//
// All outputs are registered; there is no input-to-output combinational path.
// -----------------------------------------------------------------------------
module spi_wb_bridge
  import spi_wb_pkg::*;
#(
  parameter int AW      = 7,    // 1..7, address bits taken from the command byte
  parameter int TIMEOUT = 255   // clk cycles to wait for wb_ack
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_stb,
  output logic [7:0]    tx_data,
  output logic          tx_stb,
  input  logic          tx_ready,
  output logic          wb_cyc,
  output logic          wb_stb,
  output logic          wb_we,
  output logic [AW-1:0] wb_adr,
  output logic [7:0]    wb_dat_o,
  input  logic [7:0]    wb_dat_i,
  input  logic          wb_ack,
  output logic [7:0]    overrun,
  output logic          timeout
);

  // Wide enough to hold TIMEOUT itself.
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state;
  logic          we_q;      // latched command direction
  logic [CW-1:0] to_cnt;    // cycles spent in WB_WAIT without ack

  // Address field of the incoming command byte; bits above AW are ignored.
  logic [CMD_ADR_MSB:0] cmd_adr;
  assign cmd_adr = rx_data[CMD_ADR_MSB:0];

  // A command is in flight: new bytes cannot be accepted and are dropped.
  logic busy;
  assign busy = (state == WB_REQ) || (state == WB_WAIT) || (state == TX_PUSH);

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others, matching hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      to_cnt   <= '0;
      tx_data  <= 8'h00;
      tx_stb   <= 1'b0;
      wb_cyc   <= 1'b0;
      wb_stb   <= 1'b0;
      wb_we    <= 1'b0;
      wb_adr   <= '0;
      wb_dat_o <= 8'h00;
      overrun  <= 8'h00;
      timeout  <= 1'b0;
    end else begin
      // Dropped-byte counter runs independently of the state transitions,
      // so a byte that races the tx handshake is still counted.
      if (busy && rx_stb && (overrun != 8'hFF)) begin
        overrun <= overrun + 8'd1;
      end

      case (state)
        IDLE: begin
          if (rx_stb) begin
            we_q   <= rx_data[CMD_WE_BIT];
            wb_adr <= cmd_adr[AW-1:0];
            state  <= rx_data[CMD_WE_BIT] ? GET_DATA : WB_REQ;
          end
        end

        GET_DATA: begin
          if (rx_stb) begin
            wb_dat_o <= rx_data;
            state    <= WB_REQ;
          end
        end

        WB_REQ: begin
          wb_cyc <= 1'b1;
          wb_stb <= 1'b1;
          wb_we  <= we_q;
          to_cnt <= '0;
          state  <= WB_WAIT;
        end

        WB_WAIT: begin
          if (wb_ack) begin
            // Ack is checked first, so an ack on the final wait cycle wins
            // over the timeout.
            wb_cyc <= 1'b0;
            wb_stb <= 1'b0;
            wb_we  <= 1'b0;
            if (we_q) begin
              state <= IDLE;
            end else begin
              tx_data <= wb_dat_i;
              tx_stb  <= 1'b1;
              state   <= TX_PUSH;
            end
          end else begin
            // to_cnt counts completed no-ack cycles; when this cycle brings
            // it to TIMEOUT, the bus has been held for TIMEOUT cycles.
            to_cnt <= to_cnt + CW'(1);
            if (to_cnt == CW'(TIMEOUT - 1)) begin
              wb_cyc  <= 1'b0;
              wb_stb  <= 1'b0;
              wb_we   <= 1'b0;
              timeout <= 1'b1;
              if (we_q) begin
                state <= IDLE;
              end else begin
                tx_data <= RD_ERR_BYTE;
                tx_stb  <= 1'b1;
                state   <= TX_PUSH;
              end
            end
          end
        end

        TX_PUSH: begin
          // tx_stb is always high here; tx_data is untouched until accepted.
          if (tx_ready) begin
            tx_stb <= 1'b0;
            state  <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : spi_wb_bridge

// File: doc/spi_wb_bridge.md
Name: spi_wb_bridge

Overview:
Downstream consumer of the SPI receive path, in the system clock domain. Takes bytes delivered by the clock-domain importer as one-cycle strobes. Parses a 1- or 2-byte command protocol, runs single Wishbone classic cycles (8-bit data), and pushes read results to the SPI transmit path over a valid/ready handshake. Handles protocol errors, overruns and bus timeouts locally.

Parameters:
AW, 7, Wishbone address width; the command byte carries addr[AW-1:0], and AW must be 7 or less.
TIMEOUT, 255, clk cycles to wait for wb_ack before aborting; the counter width is $clog2(TIMEOUT+1).

Ports:
clk  in  1  system clock; the only clock in the block.
rst  in  1  synchronous, active-high reset.
rx_data  in  8  received byte; valid only while rx_stb is high.
rx_stb  in  1  one-cycle strobe: a new byte is present.
tx_data  out  8  read-result byte to the SPI transmit path.
tx_stb  out  1  tx_data valid; holds until tx_ready.
tx_ready  in  1  transmit path accepts tx_data this cycle.
wb_cyc  out  1  Wishbone cycle.
wb_stb  out  1  Wishbone strobe.
wb_we  out  1  Wishbone write enable.
wb_adr  out  AW  Wishbone address.
wb_dat_o  out  8  Wishbone write data.
wb_dat_i  in  8  Wishbone read data.
wb_ack  in  1  Wishbone acknowledge.
overrun  out  8  saturating count of bytes dropped while busy.
timeout  out  1  sticky flag: a bus cycle was aborted.

Behaviour:
- Reset: state=IDLE. All outputs are 0: tx_stb, tx_data, wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o, overrun, timeout.
- Command byte layout: bit7=we, bits6:0=addr. Only addr[AW-1:0] is used; the remaining address bits are ignored.
- IDLE:
  - On rx_stb, latch we and addr.
  - If we=1, go to GET_DATA.
  - If we=0, go to WB_REQ.
- GET_DATA: on rx_stb, latch wb_dat_o=rx_data and go to WB_REQ.
- WB_REQ: one cycle. Assert wb_cyc=wb_stb=1 registered, wb_we=latched we, clear the timeout counter, then go to WB_WAIT.
- WB_WAIT: wb_cyc and wb_stb stay high until wb_ack is sampled high. On ack:
  - Drop wb_cyc, wb_stb and wb_we on the next edge.
  - For a write, return to IDLE.
  - For a read, latch tx_data=wb_dat_i, set tx_stb=1 and go to TX_PUSH.
- WB_WAIT timeout: the counter increments each cycle without ack. When the count equals TIMEOUT:
  - Drop the cycle and set timeout=1 (sticky until rst).
  - For a read, push tx_data=8'hFF.
  - For a write, return to IDLE.
- TX_PUSH: tx_stb and tx_data are held stable. In the cycle where tx_stb and tx_ready are both high, clear tx_stb and go to IDLE.
- Latency:
  - Read: the last command byte strobe is followed by wb_stb 2 cycles later.
  - Write: the data byte strobe is followed by wb_stb 2 cycles later.
  - Ack to tx_stb: 1 cycle.
- Bytes arriving while busy: an rx_stb in WB_REQ, WB_WAIT or TX_PUSH is dropped and overrun increments, saturating at 8'hFF. These bytes are never queued.
- Simultaneous events:
  - rx_stb in the same cycle as the tx handshake in TX_PUSH: the byte is dropped and overrun increments. The state still returns to IDLE.
  - wb_ack in the same cycle as the counter reaching TIMEOUT: ack wins and the timeout flag is not set.
- Mid-operation reset: an active bus cycle is dropped immediately, with wb_cyc=0 on the edge after rst is sampled. Pending tx data is discarded.
- No combinational path from any input to any output; every output is registered.

Decomposition:
- Shared package spi_wb_pkg holds:
  - state enum {IDLE, GET_DATA, WB_REQ, WB_WAIT, TX_PUSH}
  - command field constants CMD_WE_BIT=7 and CMD_ADR_MSB=6
  - the timeout fill byte RD_ERR_BYTE=8'hFF
- No sub-module. The FSM, timeout counter and overrun counter live in one file. The CDC importer stays a separate instance in the parent.

Test Plan:
- Write: rx bytes 8'h85 then 8'h3C -> one cycle with wb_we=1, wb_adr=5, wb_dat_o=8'h3C; ack after 3 cycles -> wb_cyc low; no tx_stb.
- Read: rx byte 8'h12, slave returns 8'hA7 with ack -> tx_stb=1 and tx_data=8'hA7. tx_ready held low 4 cycles keeps both stable; tx_ready high clears tx_stb and the state returns to IDLE.
- Timeout: read of addr 3 with no ack -> wb_cyc drops after TIMEOUT cycles, timeout=1, tx_data=8'hFF. Next command executes normally and timeout remains 1.
- Overrun: 3 extra rx_stb during WB_WAIT -> overrun=3, no extra bus cycles. With 300 dropped bytes, overrun saturates at 8'hFF.
- Edge races:
  - ack in the same cycle the counter hits TIMEOUT -> timeout stays 0 and the data is delivered.
  - rx_stb in the same cycle as the tx handshake -> overrun+1 and the state returns to IDLE.
- Reset in WB_WAIT -> wb_cyc=0 next cycle; all outputs 0; a following write command completes correctly.
